// File: rtl/ibex_pkg.sv
// Shared fetch-path constants for the Ibex instruction fetch unit.
package ibex_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH = 3;
  localparam int unsigned FETCH_NUM_REQS   = 2;

endpackage

// File: rtl/ibex_instr_req_ctrl.sv
// Instruction bus initiator: issues word fetches, tracks outstanding
// responses and pushes them into the fetch FIFO.
module ibex_instr_req_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = FETCH_NUM_REQS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         stored_addr_q, stored_addr_d;
  logic [31:0]         branch_addr_q, branch_addr_d;
  logic                branch_pend_q, branch_pend_d;

  logic [NUM_REQS-1:0] occ_rev;
  logic [NUM_REQS-1:0] out_s;
  logic [NUM_REQS-1:0] disc_s;
  logic [31:0]         target;
  logic                cap_ok;
  logic                req_ok;
  logic                grant;
  logic                stale;
  logic                resp;

  assign target       = {addr_i[31:2], 2'b00};
  assign resp         = instr_rvalid_i & outstanding_q[0];
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_valid_o = resp & ~discard_q[0] & ~branch_i;
  assign busy_o       = outstanding_q[0] | (state_q == WAIT_GNT);

  // FIFO occupancy plus in-flight requests must stay within NUM_REQS
  always_comb begin
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      occ_rev[i] = outstanding_q[int'(NUM_REQS) - 1 - i];
    end
    cap_ok = ~&(fifo_busy_i | occ_rev);
    req_ok = req_i & ~outstanding_q[NUM_REQS-1] & (branch_i | cap_ok);
  end

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    stored_addr_d = stored_addr_q;
    branch_addr_d = branch_addr_q;
    branch_pend_d = branch_pend_q;
    instr_req_o   = 1'b0;
    instr_addr_o  = fetch_addr_q;
    stale         = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_req_o  = req_ok;
        instr_addr_o = branch_i ? target : fetch_addr_q;
        if (req_ok) begin
          if (instr_gnt_i) begin
            fetch_addr_d = instr_addr_o + 32'd4;
          end else begin
            state_d       = WAIT_GNT;
            stored_addr_d = instr_addr_o;
          end
        end else if (branch_i) begin
          fetch_addr_d = target;
        end
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = stored_addr_q;
        if (branch_i) begin
          branch_addr_d = target;
          branch_pend_d = 1'b1;
        end
        if (instr_gnt_i) begin
          state_d       = IDLE;
          branch_pend_d = 1'b0;
          stale         = branch_i | branch_pend_q;
          if (branch_i) begin
            fetch_addr_d = target;
          end else if (branch_pend_q) begin
            fetch_addr_d = branch_addr_q;
          end else begin
            fetch_addr_d = stored_addr_q + 32'd4;
          end
        end
      end
      default: ;
    endcase
  end

  // Shift out the retiring response, then mark stale, then append the grant
  always_comb begin
    grant  = instr_req_o & instr_gnt_i;
    out_s  = resp ? (outstanding_q >> 1) : outstanding_q;
    disc_s = resp ? (discard_q >> 1) : discard_q;
    if (branch_i) begin
      disc_s = disc_s | out_s;
    end
    outstanding_d = out_s;
    discard_d     = disc_s;
    if (grant) begin
      outstanding_d = (out_s << 1) | {{(NUM_REQS-1){1'b0}}, 1'b1};
      if (stale) begin
        discard_d = disc_s | (outstanding_d & ~out_s);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= '0;
      stored_addr_q <= '0;
      branch_addr_q <= '0;
      branch_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_addr_q  <= fetch_addr_d;
      stored_addr_q <= stored_addr_d;
      branch_addr_q <= branch_addr_d;
      branch_pend_q <= branch_pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && instr_rvalid_i) begin
      assert (outstanding_q[0]);
    end
  end

endmodule

// File: tb/tb_ibex_instr_req_ctrl.sv
// Directed self-checking bench for ibex_instr_req_ctrl.
module tb_ibex_instr_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        branch;
  logic [31:0] addr;
  logic        busy;
  logic [1:0]  fifo_busy;
  logic        fifo_clear;
  logic        fifo_valid;
  logic [31:0] fifo_addr;
  logic [31:0] fifo_rdata;
  logic        fifo_err;
  logic        ireq;
  logic        gnt;
  logic [31:0] iaddr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  ibex_instr_req_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .branch_i       (branch),
    .addr_i         (addr),
    .busy_o         (busy),
    .fifo_busy_i    (fifo_busy),
    .fifo_clear_o   (fifo_clear),
    .fifo_valid_o   (fifo_valid),
    .fifo_addr_o    (fifo_addr),
    .fifo_rdata_o   (fifo_rdata),
    .fifo_err_o     (fifo_err),
    .instr_req_o    (ireq),
    .instr_gnt_i    (gnt),
    .instr_addr_o   (iaddr),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .instr_err_i    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle; combinational outputs settle before the check
  task automatic drive(input logic r, input logic q, input logic b,
                       input logic [31:0] a, input logic [1:0] fb,
                       input logic g, input logic rv,
                       input logic [31:0] rd, input logic e);
    @(negedge clk);
    rst = r; req = q; branch = b; addr = a; fifo_busy = fb;
    gnt = g; rvalid = rv; rdata = rd; err = e;
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; branch = 1'b0; addr = '0;
    fifo_busy = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
    repeat (2) @(posedge clk);

    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("rst_req", ireq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", fifo_valid, 0);

    // streaming fetch, gnt high, 1-cycle response latency
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("s0_req", ireq, 1);
    chk("s0_addr", iaddr, 32'h0);
    drive(0, 1, 0, 0, 2'b00, 1, 1, 32'hA0, 0);
    chk("s1_req", ireq, 1);
    chk("s1_addr", iaddr, 32'h4);
    chk("s1_valid", fifo_valid, 1);
    chk("s1_rdata", fifo_rdata, 32'hA0);
    chk("s1_busy", busy, 1);
    drive(0, 1, 0, 0, 2'b00, 1, 1, 32'hA4, 0);
    chk("s2_addr", iaddr, 32'h8);
    chk("s2_valid", fifo_valid, 1);
    drive(0, 0, 0, 0, 2'b00, 0, 1, 32'hA8, 0);
    chk("s3_req", ireq, 0);
    chk("s3_valid", fifo_valid, 1);
    chk("s3_rdata", fifo_rdata, 32'hA8);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("s4_busy", busy, 0);

    // branch while waiting for grant
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("w0_addr", iaddr, 32'h0);
    drive(0, 1, 1, 32'h102, 2'b00, 0, 0, 0, 0);
    chk("w1_req", ireq, 1);
    chk("w1_addr", iaddr, 32'h0);
    chk("w1_clear", fifo_clear, 1);
    chk("w1_faddr", fifo_addr, 32'h102);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("w2_req", ireq, 1);
    chk("w2_addr", iaddr, 32'h0);
    chk("w2_clear", fifo_clear, 0);
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("w3_addr", iaddr, 32'h0);
    drive(0, 1, 0, 0, 2'b00, 0, 1, 32'hBAD, 0);
    chk("w4_valid", fifo_valid, 0);
    chk("w4_addr", iaddr, 32'h100);
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("w5_addr", iaddr, 32'h100);
    drive(0, 0, 0, 0, 2'b00, 0, 1, 32'hC100, 0);
    chk("w6_valid", fifo_valid, 1);
    chk("w6_rdata", fifo_rdata, 32'hC100);

    // FIFO full blocks; freeing it issues in the same cycle
    drive(0, 1, 0, 0, 2'b11, 1, 0, 0, 0);
    chk("f0_req", ireq, 0);
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("f1_req", ireq, 1);
    chk("f1_addr", iaddr, 32'h104);

    // two outstanding, then branch
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("b0_addr", iaddr, 32'h108);
    drive(0, 1, 1, 32'h200, 2'b00, 1, 0, 0, 0);
    chk("b1_req_full", ireq, 0);
    chk("b1_clear", fifo_clear, 1);
    drive(0, 1, 0, 0, 2'b00, 0, 1, 32'h104, 0);
    chk("b2_valid", fifo_valid, 0);
    chk("b2_req", ireq, 0);
    drive(0, 1, 0, 0, 2'b00, 1, 1, 32'h108, 0);
    chk("b3_valid", fifo_valid, 0);
    chk("b3_req", ireq, 1);
    chk("b3_addr", iaddr, 32'h200);
    drive(0, 0, 0, 0, 2'b00, 0, 1, 32'hD200, 1);
    chk("b4_valid", fifo_valid, 1);
    chk("b4_rdata", fifo_rdata, 32'hD200);
    chk("b4_err", fifo_err, 1);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("b5_busy", busy, 0);

    // capacity waived on branch
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("c0_addr", iaddr, 32'h204);
    drive(0, 1, 0, 0, 2'b01, 1, 0, 0, 0);
    chk("c1_req", ireq, 0);
    drive(0, 1, 1, 32'h301, 2'b01, 1, 0, 0, 0);
    chk("c2_req", ireq, 1);
    chk("c2_addr", iaddr, 32'h300);
    drive(0, 0, 0, 0, 2'b00, 0, 1, 32'h204, 0);
    chk("c3_valid", fifo_valid, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 1, 32'hE300, 0);
    chk("c4_valid", fifo_valid, 1);
    chk("c4_rdata", fifo_rdata, 32'hE300);

    // reset mid-operation, then a stray response
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("r0_addr", iaddr, 32'h304);
    drive(0, 1, 0, 0, 2'b00, 1, 0, 0, 0);
    chk("r1_addr", iaddr, 32'h308);
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 2'b00, 0, 1, 32'hF00, 0);
    chk("r2_valid", fifo_valid, 0);
    chk("r2_req", ireq, 0);
    chk("r2_busy", busy, 0);
    drive(0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("r3_addr", iaddr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
